// File: rtl/non_max_suppress.sv
// Non-maximum suppression over a sliding 3x3 gradient-magnitude window.
// Columns stream in one per clock; the centre pixel survives only if it is a local maximum along its gradient angle.
module non_max_suppress #(
    parameter int BIT_LENGTH     = 5,
    parameter int BIT_LENGTH_ANG = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [BIT_LENGTH-1:0]     mag_in0,
    input  logic [BIT_LENGTH-1:0]     mag_in1,
    input  logic [BIT_LENGTH-1:0]     mag_in2,
    input  logic [BIT_LENGTH_ANG-1:0] ang_in1,
    output logic [BIT_LENGTH-1:0]     pixel_out,
    output logic                      readable
);

    typedef enum logic [1:0] {
        LOAD    = 2'b00,
        OPERATE = 2'b01,
        OVER    = 2'b10
    } state_t;

    state_t state;

    logic [BIT_LENGTH-1:0]     col0 [3];
    logic [BIT_LENGTH-1:0]     col1 [3];
    logic [BIT_LENGTH-1:0]     col2 [3];
    logic [BIT_LENGTH_ANG-1:0] ang1;
    logic [BIT_LENGTH_ANG-1:0] ang2;
    logic [1:0]                fill_cnt;

    logic [BIT_LENGTH-1:0] centre;
    logic [BIT_LENGTH-1:0] nb_a;
    logic [BIT_LENGTH-1:0] nb_b;
    logic [BIT_LENGTH-1:0] result;
    logic                  fire;

    // The window shifts on every edge regardless of enable; only the
    // FSM/fill counter decide whether the centre is a real image pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                col0[r] <= '0;
                col1[r] <= '0;
                col2[r] <= '0;
            end
            ang1 <= '0;
            ang2 <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                col0[r] <= col1[r];
                col1[r] <= col2[r];
            end
            col2[0] <= mag_in0;
            col2[1] <= mag_in1;
            col2[2] <= mag_in2;
            ang1    <= ang2;
            ang2    <= ang_in1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= 2'd0;
        end else if (enable && fill_cnt != 2'd3) begin
            fill_cnt <= fill_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            case (state)
                LOAD:    state <= enable ? OPERATE : LOAD;
                OPERATE: state <= enable ? OPERATE : OVER;
                OVER:    state <= OVER;
                default: state <= OVER;
            endcase
        end
    end

    always_comb begin
        centre = col1[1];
        nb_a   = col0[1];
        nb_b   = col2[1];
        case (ang1)
            BIT_LENGTH_ANG'(0): begin nb_a = col0[1]; nb_b = col2[1]; end
            BIT_LENGTH_ANG'(1): begin nb_a = col0[2]; nb_b = col2[0]; end
            BIT_LENGTH_ANG'(2): begin nb_a = col1[0]; nb_b = col1[2]; end
            BIT_LENGTH_ANG'(3): begin nb_a = col0[0]; nb_b = col2[2]; end
            default:            begin nb_a = col0[1]; nb_b = col2[1]; end
        endcase
        result = (centre >= nb_a && centre >= nb_b) ? centre : '0;
    end

    assign fire = (state == OPERATE) && (fill_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out <= '0;
            readable  <= 1'b0;
        end else begin
            pixel_out <= fire ? result : '0;
            readable  <= fire;
        end
    end

endmodule

// File: tb/tb_non_max_suppress.sv
// Bench for non_max_suppress: a column-history reference model predicts
// readable/pixel_out after every edge; directed and random scenarios follow.
module tb_non_max_suppress;

    localparam int W = 5;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [W-1:0] m0;
        logic [W-1:0] m1;
        logic [W-1:0] m2;
        logic [1:0]   a;
    } col_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] mag_in0 = '0;
    logic [W-1:0] mag_in1 = '0;
    logic [W-1:0] mag_in2 = '0;
    logic [1:0]   ang_in1 = '0;
    logic [W-1:0] pixel_out;
    logic         readable;

    col_t         hist[$];
    int           mode;
    int           en_cnt;
    logic         exp_rd;
    logic [W-1:0] exp_px;
    int           checks = 0;
    int           errors = 0;

    non_max_suppress #(.BIT_LENGTH(W), .BIT_LENGTH_ANG(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mag_in0   (mag_in0),
        .mag_in1   (mag_in1),
        .mag_in2   (mag_in2),
        .ang_in1   (ang_in1),
        .pixel_out (pixel_out),
        .readable  (readable)
    );

    always #5 clk = ~clk;

    function automatic col_t mk(input int m0, input int m1, input int m2, input int a);
        col_t c;
        c.m0 = W'(m0);
        c.m1 = W'(m1);
        c.m2 = W'(m2);
        c.a  = 2'(a);
        return c;
    endfunction

    function automatic col_t rnd_col();
        return mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
    endfunction

    // Reference: pick the two neighbours along the centre's gradient angle.
    function automatic logic [W-1:0] ref_nms(input col_t l, input col_t c, input col_t r);
        int n1, n2;
        case (c.a)
            2'd0:    begin n1 = l.m1; n2 = r.m1; end
            2'd1:    begin n1 = l.m2; n2 = r.m0; end
            2'd2:    begin n1 = c.m0; n2 = c.m2; end
            default: begin n1 = l.m0; n2 = r.m2; end
        endcase
        return (int'(c.m1) >= n1 && int'(c.m1) >= n2) ? c.m1 : '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        mode   = M_IDLE;
        en_cnt = 0;
        exp_rd = 1'b0;
        exp_px = '0;
    endtask

    // Drive one column, clock it, and advance the reference model.
    task automatic step(input logic en, input col_t col);
        logic fire;
        enable  = en;
        mag_in0 = col.m0;
        mag_in1 = col.m1;
        mag_in2 = col.m2;
        ang_in1 = col.a;
        @(posedge clk);
        fire   = (mode == M_RUN) && (en_cnt >= 3);
        exp_rd = fire;
        exp_px = fire ? ref_nms(hist[0], hist[1], hist[2]) : '0;
        hist.push_back(col);
        void'(hist.pop_front());
        if (en) en_cnt++;
        if (mode == M_IDLE && en) mode = M_RUN;
        else if (mode == M_RUN && !en) mode = M_DONE;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (readable !== 1'b0 || pixel_out !== '0) begin
            errors++;
            $display("FAIL reset_state: readable=%b pixel_out=%0d, expected 0/0", readable, pixel_out);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(5, 5, 5, 0));
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL fill[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_zero_deg();
        col_t seq[10];
        seq = '{mk(0, 6, 0, 0), mk(0, 4, 0, 0), mk(0, 2, 0, 0), mk(7, 7, 7, 0), mk(7, 7, 7, 0),
                mk(0, 6, 0, 0), mk(0, 4, 0, 2), mk(0, 2, 0, 0), mk(7, 7, 7, 0), mk(7, 7, 7, 0)};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL zero_deg[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_diagonals();
        col_t seq[10];
        seq = '{mk(1, 0, 12, 0), mk(0, 9, 0, 1), mk(3, 0, 1, 0), mk(2, 2, 2, 0), mk(2, 2, 2, 0),
                mk(1, 0, 12, 0), mk(0, 9, 0, 3), mk(3, 0, 1, 0), mk(2, 2, 2, 0), mk(2, 2, 2, 0)};
        for (int i = 0; i < 10; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL diagonal[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk(31, 31, 31, i % 4));
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL extreme_max[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(0, 0, 0, i % 4));
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL extreme_zero[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            step(1'b1, rnd_col());
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL random[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_drain();
        logic en_seq[8];
        en_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(en_seq[i], rnd_col());
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL drain[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rnd_col());
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL pre_reset[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (readable !== 1'b0 || pixel_out !== '0) begin
            errors++;
            $display("FAIL async_reset: readable=%b pixel_out=%0d, expected 0/0", readable, pixel_out);
        end
        model_reset();
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rnd_col());
            checks++;
            if (readable !== exp_rd || pixel_out !== exp_px) begin
                errors++;
                $display("FAIL refill[%0d]: readable=%b pixel_out=%0d, expected %b/%0d", i, readable, pixel_out, exp_rd, exp_px);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_zero_deg();
        test_diagonals();
        test_extremes();
        test_random();
        test_drain();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
